mem_access_unit: RTL and testbench

//   Load/store stage directly downstream of the ALU. Takes the ALU Result as the effective address for
//   lw/lh/lhu/lb/lbu/sw/sh/sb and runs one handshaked data-memory transaction per request. Does the

---
 rtl/mem_access_unit.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage: one handshaked data-memory access per request.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned word/halfword accesses without a bus cycle).
module mem_access_unit #(
  parameter int DP_WIDTH    = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            mem_op,
  input  logic [DP_WIDTH-1:0]   addr,
  input  logic [DP_WIDTH-1:0]   wdata,
  input  logic [4:0]            rd_in,
  output logic                  resp_valid,
  output logic [DP_WIDTH-1:0]   resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_err,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DP_WIDTH-1:0]   dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DP_WIDTH-1:0]   dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DP_WIDTH-1:0]   dmem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]          state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DP_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]          resp_rd_q, resp_rd_d;
  logic                resp_err_q, resp_err_d;
  logic                dmem_we_q, dmem_we_d;
  logic [DP_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]          dmem_be_q, dmem_be_d;
  logic [DP_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;

  logic                misalign;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DP_WIDTH-1:0] load_ext;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (mem_op)
      OP_LW, OP_SW:          misalign = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misalign = addr[0];
      default:               misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Lane extraction uses the captured address bits, not the live request port.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_q)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_ext = '0;
    case (op_q)
      OP_LW:   load_ext = dmem_rdata;
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0000, half_sel};
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h000000, byte_sel};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_lo_d    = addr_lo_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d         = mem_op;
          addr_lo_d    = addr[1:0];
          cnt_d        = '0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          resp_rd_d    = (mem_op <= OP_LBU) ? rd_in : 5'd0;
          dmem_we_d    = (mem_op >= OP_SW);
          dmem_addr_d  = {addr[DP_WIDTH-1:2], 2'b00};
          case (mem_op)
            OP_SH: begin
              dmem_be_d    = addr[1] ? 4'b1100 : 4'b0011;
              dmem_wdata_d = {2{wdata[15:0]}};
            end
            OP_SB: begin
              dmem_be_d    = 4'b0001 << addr[1:0];
              dmem_wdata_d = {4{wdata[7:0]}};
            end
            default: begin
              dmem_be_d    = 4'b1111;
              dmem_wdata_d = wdata;
            end
          endcase
          if (misalign) begin
            resp_err_d = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d    = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // An ack arriving on the final timeout cycle still completes normally.
        if (dmem_ack) begin
          resp_rdata_d = load_ext;
          state_d      = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      addr_lo_q    <= 2'd0;
      cnt_q        <= '0;
      resp_rdata_q <= '0;
      resp_rd_q    <= 5'd0;
      resp_err_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= 4'b0000;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_lo_q    <= addr_lo_d;
      cnt_q        <= cnt_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign dmem_req   = (state_q == S_ACCESS);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  mem_op = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .addr(addr), .wdata(wdata), .rd_in(rd_in),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  // Presents one request for a single cycle; returns at the negedge of the first post-accept cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
    @(negedge clk);
    mem_op = op; addr = a; wdata = wd; rd_in = rd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, dmem_req, dmem_we} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 10000", {req_ready, resp_valid, resp_err, dmem_req, dmem_we});
    end
    n_checks++;
    if ({resp_rdata, resp_rd, dmem_addr, dmem_be, dmem_wdata} !== 105'd0) begin
      n_fail++; $display("FAIL reset_data rdata=%h rd=%0d addr=%h be=%b wdata=%h want all 0",
                         resp_rdata, resp_rd, dmem_addr, dmem_be, dmem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sw;
    issue(3'd5, 32'h100, 32'hDEADBEEF, 5'd9);
    n_checks++;
    if ({dmem_req, dmem_we, dmem_be, req_ready} !== 7'b1111110) begin
      n_fail++; $display("FAIL sw_ctrl req=%b we=%b be=%b ready=%b want 1 1 1111 0", dmem_req, dmem_we, dmem_be, req_ready);
    end
    n_checks++;
    if (dmem_addr !== 32'h100 || dmem_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL sw_bus addr=%h wdata=%h want 00000100 deadbeef", dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++;
    if ({resp_valid, resp_err, dmem_req} !== 3'b100 || resp_rd !== 5'd0 || resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL sw_resp valid=%b err=%b req=%b rd=%0d rdata=%h want 1 0 0 0 0",
                         resp_valid, resp_err, dmem_req, resp_rd, resp_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL sw_pulse valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  ops [4] = '{3'd3, 3'd4, 3'd1, 3'd2};
    logic [31:0] adrs[4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], adrs[i], 32'h0, 5'(i + 3));
      n_checks++;
      if (dmem_we !== 1'b0 || dmem_be !== 4'b1111 || dmem_addr !== 32'h100) begin
        n_fail++; $display("FAIL load%0d_bus we=%b be=%b addr=%h want 0 1111 00000100", i, dmem_we, dmem_be, dmem_addr);
      end
      dmem_rdata = 32'h80FF1234; dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== exps[i] || resp_rd !== 5'(i + 3)) begin
        n_fail++; $display("FAIL load%0d_resp valid=%b err=%b rdata=%h rd=%0d want 1 0 %h %0d",
                           i, resp_valid, resp_err, resp_rdata, resp_rd, exps[i], i + 3);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sb;
    issue(3'd7, 32'h1001, 32'h000000AB, 5'd0);
    n_checks++;
    if (dmem_addr !== 32'h1000 || dmem_be !== 4'b0010 || dmem_wdata !== 32'hABABABAB || dmem_we !== 1'b1) begin
      n_fail++; $display("FAIL sb_bus addr=%h be=%b wdata=%h we=%b want 00001000 0010 abababab 1",
                         dmem_addr, dmem_be, dmem_wdata, dmem_we);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);
    issue(3'd6, 32'h2002, 32'h0000CAFE, 5'd0);
    n_checks++;
    if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hCAFECAFE) begin
      n_fail++; $display("FAIL sh_bus be=%b wdata=%h want 1100 cafecafe", dmem_be, dmem_wdata);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int hi = 0;
    issue(3'd0, 32'h200, 32'h0, 5'd4);
    while (dmem_req === 1'b1 && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    n_checks++;
    if (hi != 16) begin
      n_fail++; $display("FAIL timeout_len req_cycles=%0d want 16", hi);
    end
    n_checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL timeout_resp valid=%b err=%b rdata=%h want 1 1 0", resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
    repeat (2) @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || dmem_req !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL stray_ack valid=%b req=%b ready=%b want 0 0 1", resp_valid, dmem_req, req_ready);
    end
  endtask

  task automatic test_ack_at_timeout;
    issue(3'd0, 32'h300, 32'h0, 5'd7);
    repeat (15) @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL late_ack_req req=%b want 1", dmem_req);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL late_ack_resp valid=%b err=%b rdata=%h want 1 0 0badf00d", resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign;
    issue(3'd0, 32'h102, 32'h0, 5'd2);
`ifdef MISALIGN_TRAP_EN
    n_checks++;
    if (dmem_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL misalign_trap req=%b valid=%b err=%b rdata=%h want 0 1 1 0",
                         dmem_req, resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
`else
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin
      n_fail++; $display("FAIL misalign_bus req=%b addr=%h want 1 00000100", dmem_req, dmem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h11223344) begin
      n_fail++; $display("FAIL misalign_resp valid=%b err=%b rdata=%h want 1 0 11223344", resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_rst_mid;
    int seen = 0;
    issue(3'd0, 32'h400, 32'h0, 5'd1);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_async req=%b want 0", dmem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    dmem_ack = 1'b0;
    n_checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_abandon resp_pulses=%0d ready=%b want 0 1", seen, req_ready);
    end
  endtask

  initial begin
    test_reset;
    test_sw;
    test_loads;
    test_sb;
    test_timeout;
    test_ack_at_timeout;
    test_misalign;
    test_rst_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
